// File: rtl/simplez_pkg.sv
// Simplez shared definitions: opcodes, sequencer states and instruction field macros.
`ifndef SIMPLEZ_PKG_SV
`define SIMPLEZ_PKG_SV

`define SIMPLEZ_CO(ri, dw) ri[(dw)-1 -: 3]
`define SIMPLEZ_CD(ri, aw) ri[(aw)-1:0]

package simplez_pkg;

    typedef enum logic [2:0] {
        OP_ST   = 3'd0,
        OP_LD   = 3'd1,
        OP_ADD  = 3'd2,
        OP_BR   = 3'd3,
        OP_BZ   = 3'd4,
        OP_CLR  = 3'd5,
        OP_DEC  = 3'd6,
        OP_HALT = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        OPER   = 2'd2,
        HALTED = 2'd3
    } state_t;

endpackage

`endif

// File: rtl/simplez_if.sv
// Simplez memory bus: a rd or wr request is held, with stable address/data, until ready completes it.
interface simplez_if #(
    parameter int DATAW = 12,
    parameter int ADDRW = 9
);
    logic [ADDRW-1:0] mem_addr;
    logic             mem_rd;
    logic             mem_wr;
    logic [DATAW-1:0] mem_wdata;
    logic [DATAW-1:0] mem_rdata;
    logic             mem_ready;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/simplez_seq.sv
// Simplez sequencer: FETCH/DECODE/OPER/HALTED state register plus the bus requests and
// datapath strobes for each state. Reset gates every output so a pending request drops at once.
module simplez_seq
    import simplez_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  opcode_t co,
    input  logic    mem_ready,
    input  logic    is_io,
    output state_t  state,
    output logic    mem_rd,
    output logic    mem_wr,
    output logic    ri_load,
    output logic    cp_jump,
    output logic    cp_jump_zero,
    output logic    ac_load,
    output logic    ac_add,
    output logic    ac_clear,
    output logic    ac_dec,
    output logic    io_load,
    output logic    stop
);
    state_t next_state;

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state   = state;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        ri_load      = 1'b0;
        cp_jump      = 1'b0;
        cp_jump_zero = 1'b0;
        ac_load      = 1'b0;
        ac_add       = 1'b0;
        ac_clear     = 1'b0;
        ac_dec       = 1'b0;
        io_load      = 1'b0;
        stop         = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        ri_load    = 1'b1;
                        next_state = DECODE;
                    end
                end
                DECODE: begin
                    next_state = FETCH;
                    case (co)
                        OP_BR:   cp_jump      = 1'b1;
                        OP_BZ:   cp_jump_zero = 1'b1;
                        OP_CLR:  ac_clear     = 1'b1;
                        OP_DEC:  ac_dec       = 1'b1;
                        OP_HALT: next_state   = HALTED;
                        default: next_state   = OPER;
                    endcase
                end
                OPER: begin
                    case (co)
                        // A store to the output port completes internally, without a bus cycle.
                        OP_ST: begin
                            if (is_io) begin
                                io_load    = 1'b1;
                                next_state = FETCH;
                            end else begin
                                mem_wr = 1'b1;
                                if (mem_ready) next_state = FETCH;
                            end
                        end
                        OP_LD: begin
                            mem_rd = 1'b1;
                            if (mem_ready) begin
                                ac_load    = 1'b1;
                                next_state = FETCH;
                            end
                        end
                        OP_ADD: begin
                            mem_rd = 1'b1;
                            if (mem_ready) begin
                                ac_add     = 1'b1;
                                next_state = FETCH;
                            end
                        end
                        default: next_state = FETCH;
                    endcase
                end
                HALTED: stop = 1'b1;
                default: next_state = FETCH;
            endcase
        end
    end
endmodule

// File: rtl/simplez_cpu.sv
// Simplez accumulator CPU: CP/RI/AC datapath around the simplez_seq sequencer.
// Defining SIMPLEZ_MMIO_EN turns stores to IO_ADDR into writes of the io_out register.
module simplez_cpu
    import simplez_pkg::*;
#(
    parameter int               DATAW    = 12,
    parameter int               ADDRW    = 9,
    parameter int               RESET_PC = 0,
    parameter logic [ADDRW-1:0] IO_ADDR  = '1
) (
    input  logic             clk,
    input  logic             rst,
    simplez_if.master        bus,
    output logic [DATAW-1:0] ac_out,
    output logic [DATAW-1:0] io_out,
    output logic             stop
);
`ifdef SIMPLEZ_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    logic [ADDRW-1:0] cp;
    logic [DATAW-1:0] ri;
    logic [DATAW-1:0] ac;
    logic [ADDRW-1:0] cd;
    opcode_t          co;
    state_t           state;
    logic             is_io;
    logic             mem_rd, mem_wr, ri_load, cp_jump, cp_jump_zero;
    logic             ac_load, ac_add, ac_clear, ac_dec, io_load;
    logic             unused_ri;

    assign co        = opcode_t'(`SIMPLEZ_CO(ri, DATAW));
    assign cd        = `SIMPLEZ_CD(ri, ADDRW);
    assign is_io     = MMIO_EN && (cd == IO_ADDR);
    assign unused_ri = ^ri;

    assign bus.mem_rd    = mem_rd;
    assign bus.mem_wr    = mem_wr;
    assign bus.mem_addr  = (state == FETCH) ? cp : cd;
    assign bus.mem_wdata = ac;
    assign ac_out        = ac;

    simplez_seq u_seq (
        .clk          (clk),
        .rst          (rst),
        .co           (co),
        .mem_ready    (bus.mem_ready),
        .is_io        (is_io),
        .state        (state),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .ri_load      (ri_load),
        .cp_jump      (cp_jump),
        .cp_jump_zero (cp_jump_zero),
        .ac_load      (ac_load),
        .ac_add       (ac_add),
        .ac_clear     (ac_clear),
        .ac_dec       (ac_dec),
        .io_load      (io_load),
        .stop         (stop)
    );

    // CP and AC arithmetic is modular: CP wraps past the top address, AC drops any carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cp     <= ADDRW'(RESET_PC);
            ri     <= '0;
            ac     <= '0;
            io_out <= '0;
        end else begin
            if (ri_load) begin
                ri <= bus.mem_rdata;
                cp <= cp + ADDRW'(1);
            end else if (cp_jump || (cp_jump_zero && ac == '0)) begin
                cp <= cd;
            end
            if (ac_load)       ac <= bus.mem_rdata;
            else if (ac_add)   ac <= ac + bus.mem_rdata;
            else if (ac_clear) ac <= '0;
            else if (ac_dec)   ac <= ac - DATAW'(1);
            if (io_load) io_out <= ac;
        end
    end
endmodule

// File: tb/tb_simplez_cpu.sv
// Bench for simplez_cpu: directed and random programs compared with an instruction-level model.
// Define SIMPLEZ_MMIO_EN for both bench and RTL to cover the memory-mapped output port.
`timescale 1ns/1ps
module tb_simplez_cpu;
    localparam int         DATAW   = 12;
    localparam int         ADDRW   = 9;
    localparam int         MEMN    = 512;
    localparam logic [8:0] IO_ADDR = 9'h1FF;
`ifdef SIMPLEZ_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] ac_out, io_out;
    logic        stop;
    logic        readyBit = 1'b1;
    logic        holdWr = 1'b0;
    int          readyPct = 100;

    logic [11:0] mem [MEMN];
    logic [21:0] txnLog [$];
    logic [21:0] expLog [$];
    logic [11:0] expAc, expIo;
    bit          expHalted;
    int          expCycles;
    int          errors = 0;
    int          checks = 0;

    simplez_if #(.DATAW(DATAW), .ADDRW(ADDRW)) bus ();

    simplez_cpu #(.DATAW(DATAW), .ADDRW(ADDRW), .RESET_PC(0), .IO_ADDR(IO_ADDR)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .ac_out (ac_out),
        .io_out (io_out),
        .stop   (stop)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr];
    assign bus.mem_ready = readyBit & ~(holdWr & bus.mem_wr);

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ready is re-rolled just after each edge so it is stable for the whole next cycle.
    always @(posedge clk) begin
        #1;
        readyBit = ($urandom_range(99) < 32'(readyPct));
    end

    // Memory slave: a request completes at the edge following a cycle with ready high.
    always @(negedge clk) begin
        if (!rst && bus.mem_ready && (bus.mem_rd || bus.mem_wr)) begin
            if (bus.mem_wr) begin
                txnLog.push_back({1'b1, bus.mem_addr, bus.mem_wdata});
                mem[bus.mem_addr] = bus.mem_wdata;
            end else begin
                txnLog.push_back({1'b0, bus.mem_addr, bus.mem_rdata});
            end
        end
    end

    // A request refused by the slave must be presented again unchanged.
    logic [22:0] lastReq;
    logic [22:0] curReq;
    logic        lastHold = 1'b0;
    always @(negedge clk) begin
        curReq = {bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata};
        checkOutput("rd_wr_exclusive", 32'(bus.mem_rd & bus.mem_wr), 32'd0);
        if (lastHold && !rst) checkOutput("req_held", 32'(curReq), 32'(lastReq));
        lastHold = !rst && (bus.mem_rd || bus.mem_wr) && !bus.mem_ready;
        lastReq  = curReq;
    end

    task automatic clearMem();
        for (int a = 0; a < MEMN; a++) mem[a] = '0;
    endtask

    // Executes the program one instruction at a time and lists the bus transfers it implies.
    task automatic runModel(input int maxInstr);
        logic [11:0] m [MEMN];
        logic [8:0]  pc, cd;
        logic [11:0] ac, ir;
        logic [2:0]  op;
        m = mem;
        pc = '0;
        ac = '0;
        expIo = '0;
        expHalted = 1'b0;
        expCycles = 0;
        expLog.delete();
        for (int n = 0; n < maxInstr && !expHalted; n++) begin
            ir = m[pc];
            expLog.push_back({1'b0, pc, ir});
            pc = pc + 9'd1;
            op = ir[11:9];
            cd = ir[8:0];
            expCycles += 2;
            case (op)
                3'd0: begin
                    expCycles += 1;
                    if (MMIO && cd == IO_ADDR) expIo = ac;
                    else begin
                        m[cd] = ac;
                        expLog.push_back({1'b1, cd, ac});
                    end
                end
                3'd1: begin
                    expCycles += 1;
                    expLog.push_back({1'b0, cd, m[cd]});
                    ac = m[cd];
                end
                3'd2: begin
                    expCycles += 1;
                    expLog.push_back({1'b0, cd, m[cd]});
                    ac = ac + m[cd];
                end
                3'd3: pc = cd;
                3'd4: if (ac == 0) pc = cd;
                3'd5: ac = '0;
                3'd6: ac = ac - 12'd1;
                default: expHalted = 1'b1;
            endcase
        end
        expAc = ac;
    endtask

    task automatic genProgram();
        int          len;
        logic [2:0]  op;
        logic [8:0]  cd;
        for (int a = 0; a < MEMN; a++) mem[a] = 12'($urandom);
        len = $urandom_range(20, 4);
        for (int pc = 0; pc < len; pc++) begin
            op = (pc == len - 1) ? 3'd7 : 3'($urandom_range(6, 0));
            case (op)
                3'd0:       cd = ($urandom_range(7) == 0) ? IO_ADDR : 9'($urandom_range(95, 64));
                3'd1, 3'd2: cd = ($urandom_range(7) == 0) ? IO_ADDR : 9'($urandom_range(95, 0));
                3'd3, 3'd4: cd = 9'($urandom_range(len - 1, pc + 1));
                default:    cd = 9'($urandom);
            endcase
            mem[pc] = {op, cd};
        end
    endtask

    // Resets the core, runs the loaded program and compares it with the model.
    task automatic applyStimulus(input string name, input int maxInstr, input int pct);
        int cycles;
        bit timedOut;
        runModel(maxInstr);
        readyPct = pct;
        holdWr = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput({name, ":rst_rd"}, 32'(bus.mem_rd), 32'd0);
        checkOutput({name, ":rst_wr"}, 32'(bus.mem_wr), 32'd0);
        checkOutput({name, ":rst_stop"}, 32'(stop), 32'd0);
        checkOutput({name, ":rst_ac"}, 32'(ac_out), 32'd0);
        checkOutput({name, ":rst_io"}, 32'(io_out), 32'd0);
        txnLog.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checkOutput({name, ":fetch0_rd"}, 32'(bus.mem_rd), 32'd1);
        checkOutput({name, ":fetch0_addr"}, 32'(bus.mem_addr), 32'd0);
        cycles = 0;
        timedOut = 1'b0;
        while (1) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
            if (stop) break;
            if (!expHalted && txnLog.size() >= expLog.size()) break;
            if (cycles > 2000) begin
                timedOut = 1'b1;
                break;
            end
        end
        checkOutput({name, ":timeout"}, 32'(timedOut), 32'd0);
        if (expHalted) begin
            checkOutput({name, ":stop"}, 32'(stop), 32'd1);
            checkOutput({name, ":ac"}, 32'(ac_out), 32'(expAc));
            checkOutput({name, ":io"}, 32'(io_out), 32'(expIo));
            checkOutput({name, ":txn_count"}, 32'(txnLog.size()), 32'(expLog.size()));
            if (pct == 100) checkOutput({name, ":cycles"}, 32'(cycles), 32'(expCycles));
            repeat (3) @(negedge clk);
            checkOutput({name, ":halt_idle"}, 32'(txnLog.size()), 32'(expLog.size()));
            checkOutput({name, ":halt_stop"}, 32'(stop), 32'd1);
        end else begin
            checkOutput({name, ":txn_count_min"}, 32'(txnLog.size() >= expLog.size()), 32'd1);
        end
        for (int i = 0; i < expLog.size() && i < txnLog.size(); i++)
            checkOutput($sformatf("%s:txn%0d", name, i), 32'(txnLog[i]), 32'(expLog[i]));
    endtask

    initial begin
        bit seen;
        $display("[TB] simplez_cpu bench, MMIO=%0d", MMIO);

        // LD 10; ADD 11; ST 12; HALT
        clearMem();
        mem[0] = {3'd1, 9'd10}; mem[1] = {3'd2, 9'd11};
        mem[2] = {3'd0, 9'd12}; mem[3] = {3'd7, 9'd0};
        mem[10] = 12'd5; mem[11] = 12'd7;
        applyStimulus("T1", 100, 100);
        checkOutput("T1:m12", 32'(mem[12]), 32'd12);

        // Taken BZ, untaken BZ, unconditional BR.
        clearMem();
        mem[0]  = {3'd4, 9'd20}; mem[20] = {3'd1, 9'd30};
        mem[21] = {3'd4, 9'd40}; mem[22] = {3'd3, 9'd7};
        mem[7]  = {3'd7, 9'd0};  mem[30] = 12'd1;
        applyStimulus("T2", 100, 60);

        // DEC from zero, ADD overflow, CP wrap from 511 to 0.
        clearMem();
        mem[0] = {3'd5, 9'd0};  mem[1] = {3'd6, 9'd0};  mem[2] = {3'd0, 9'd64};
        mem[3] = {3'd2, 9'd65}; mem[4] = {3'd0, 9'd66}; mem[5] = {3'd3, 9'd511};
        mem[511] = {3'd0, 9'd67}; mem[65] = 12'd2;
        applyStimulus("T3", 8, 100);
        checkOutput("T3:dec_wrap", 32'(mem[64]), 32'hFFF);
        checkOutput("T3:add_wrap", 32'(mem[66]), 32'h001);

        // Same as T1 with frequent wait states.
        clearMem();
        mem[0] = {3'd1, 9'd10}; mem[1] = {3'd2, 9'd11};
        mem[2] = {3'd0, 9'd12}; mem[3] = {3'd7, 9'd0};
        mem[10] = 12'd5; mem[11] = 12'd7;
        applyStimulus("T4", 100, 25);
        checkOutput("T4:m12", 32'(mem[12]), 32'd12);

        // Reset while a store is stalled in OPER.
        clearMem();
        mem[0] = {3'd1, 9'd64}; mem[1] = {3'd0, 9'd65}; mem[2] = {3'd7, 9'd0};
        mem[64] = 12'h123;
        readyPct = 100;
        holdWr = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = bus.mem_wr;
        end
        checkOutput("T5:wr_seen", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("T5:wr_held", 32'(bus.mem_wr), 32'd1);
        checkOutput("T5:addr_held", 32'(bus.mem_addr), 32'd65);
        checkOutput("T5:ac_before", 32'(ac_out), 32'h123);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("T5:wr_dropped", 32'(bus.mem_wr), 32'd0);
        checkOutput("T5:rd_idle", 32'(bus.mem_rd), 32'd0);
        checkOutput("T5:ac_reset", 32'(ac_out), 32'd0);
        @(posedge clk); #1 rst = 1'b0; holdWr = 1'b0;
        @(negedge clk);
        checkOutput("T5:refetch_rd", 32'(bus.mem_rd), 32'd1);
        checkOutput("T5:refetch_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("T5:no_write", 32'(mem[65]), 32'd0);

        // Store to the top address: output port or ordinary memory depending on the build.
        clearMem();
        mem[0] = {3'd1, 9'd64}; mem[1] = {3'd0, IO_ADDR}; mem[2] = {3'd7, 9'd0};
        mem[64] = 12'h0A5;
        applyStimulus("T6", 100, 100);
        checkOutput("T6:io", 32'(io_out), MMIO ? 32'h0A5 : 32'd0);
        checkOutput("T6:m511", 32'(mem[511]), MMIO ? 32'd0 : 32'h0A5);

        for (int t = 0; t < 16; t++) begin
            genProgram();
            applyStimulus($sformatf("R%0d", t), 100, (t % 4 == 0) ? 100 : 20 + 20 * (t % 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
